ex_mem_reg: RTL and testbench
=============================

# ex_mem_reg

Pipeline register between the execute stage and the memory-access stage of the five-stage OpenMIPS core. Each rising clock edge it captures the execute-stage result: destination register, write enable, write data, HI/LO update, and load/store operation, address and store data. It presents these to the memory-access stage, honouring the global stall vector and pipeline flush. It also provides per-instruction temporary storage for two-cycle multiply-accumulate instructions (madd/maddu/msub/msubu): an intermediate 64-bit product and a cycle counter are held while EX is stalled and fed back into EX.

## Interface
Parameters:
- none. Widths come from the shared defines:
  - `RegAddrBus` = 5 bits
  - `RegBus` = 32 bits
  - `DoubleRegBus` = 64 bits
  - `AluOpBus` = 8 bits

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-high (`RstEnable` = 1'b1)
- stall  in  6  global stall vector; bit 3 = EX stalled, bit 4 = MEM stalled
- flush  in  1  pipeline flush (exception); synchronous, highest priority after rst
- ex_wd  in  5  destination register address
- ex_wreg  in  1  register write enable
- ex_wdata  in  32  register write data
- ex_whilo  in  1  HI/LO write enable
- ex_hi  in  32  HI write value
- ex_lo  in  32  LO write value
- ex_aluop  in  8  ALU op (identifies load/store to MEM)
- ex_mem_addr  in  32  load/store effective address
- ex_reg2  in  32  store data
- hilo_i  in  64  intermediate accumulate product from EX
- cnt_i  in  2  accumulate cycle count from EX
- mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_aluop, mem_mem_addr, mem_reg2  out  (widths as the inputs)  registered copies to MEM
- hilo_o  out  64  held intermediate product back to EX
- cnt_o  out  2  held cycle count back to EX

## Operation
- All outputs are registers. Priority each edge: rst (async) > flush > stall decode.
- Reset (rst=1, immediate, no clock needed):
  - mem_wd = `NOPRegAddr` (5'b00000)
  - mem_wreg = mem_whilo = 0
  - every data, address and aluop output = 0 (mem_aluop = `EXE_NOP_OP` = 8'h00)
  - hilo_o = 0, cnt_o = 2'b00
- flush=1: load the bubble (all mem_* outputs cleared as in reset); hilo_o = 0, cnt_o = 0. Stall is ignored.
- stall[3]=1, stall[4]=0 (EX stalled, MEM running):
  - insert a bubble into MEM (all mem_* outputs cleared)
  - hilo_o <= hilo_i, cnt_o <= cnt_i, so the accumulate state survives into the next EX cycle
- stall[3]=0 (EX advancing):
  - capture every ex_* input into the matching mem_* output
  - hilo_o <= 0, cnt_o <= 0, so the accumulate state is cleared for the next instruction
- stall[3]=1, stall[4]=1: hold all mem_* outputs; hilo_o <= hilo_i, cnt_o <= cnt_i.
- stall[3]=0 with stall[4]=1 is illegal (the stall controller never asserts it). The implementation treats it as a capture; verification asserts it never occurs.
- No width conversion; all fields pass through bit-exact.

## Timing
- Latency: 1 cycle from ex_* to mem_*.
- Bubble and hold decisions use the stall and flush values sampled at the same edge as the data.
- Accumulate sequence, EX requesting stall[3] for one cycle:
  - edge N: hilo_o/cnt_o take hilo_i/cnt_i (cnt_i = 2'b01) and a bubble enters MEM
  - edge N+1: stall deasserted; the final result is captured into mem_*; hilo_o/cnt_o clear to 0
- rst asserted mid-stall or mid-accumulate clears everything immediately. The first capture occurs at the first rising edge after rst deasserts.
- flush during an accumulate discards hilo_o/cnt_o at that edge.

## Test plan
- Reset: drive arbitrary inputs, assert rst between edges -> all outputs go to 0 (mem_wd = 5'd0) before the next edge; they stay 0 while rst=1.
- Pass-through: stall=0, ex_wd=5'd3, ex_wreg=1, ex_wdata=32'h1234_5678, ex_mem_addr=32'h0000_0040 -> after one edge the mem_* outputs show the same values; hilo_o=0, cnt_o=0.
- Bubble: stall=6'b001111, ex_wreg=1, hilo_i=64'hAAAA_BBBB_CCCC_DDDD, cnt_i=2'b01 -> mem_wreg=0, mem_wd=0, hilo_o=64'hAAAA_BBBB_CCCC_DDDD, cnt_o=2'b01. Next edge with stall=0 -> the new ex_* values are captured and hilo_o=0.
- Full hold: load ex_wdata=32'hDEAD_BEEF, then stall=6'b011111 for 3 edges with changing inputs -> mem_wdata stays 32'hDEAD_BEEF throughout.
- Flush priority: flush=1 together with stall=6'b001111 and cnt_i=2'b01 -> all outputs 0, including cnt_o.
- Async reset mid-accumulate: cnt_o=2'b01; pulse rst between clock edges -> cnt_o=0 and hilo_o=0 immediately.

Source files
------------

// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX/MEM pipeline register with multiply-accumulate scratch storage
module ex_mem_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic        ex_whilo,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_reg2,
  input  logic [63:0] hilo_i,
  input  logic [1:0]  cnt_i,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic        mem_whilo,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic [7:0]  mem_aluop,
  output logic [31:0] mem_mem_addr,
  output logic [31:0] mem_reg2,
  output logic [63:0] hilo_o,
  output logic [1:0]  cnt_o
);

  localparam logic [4:0]  NOP_REG_ADDR = 5'b00000;
  localparam logic [7:0]  EXE_NOP_OP   = 8'h00;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  logic ex_stalled;
  logic mem_stalled;
  logic insert_bubble;
  logic hold_mem;

  // Decode the stall vector; EX advancing always captures, even if MEM claims a stall
  always_comb begin
    ex_stalled    = stall[3];
    mem_stalled   = stall[4];
    insert_bubble = ex_stalled && !mem_stalled;
    hold_mem      = ex_stalled && mem_stalled;
  end

  // MEM-facing result registers: bubble on reset/flush/EX-only stall, hold when both stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wd       <= NOP_REG_ADDR;
      mem_wreg     <= 1'b0;
      mem_wdata    <= ZERO_WORD;
      mem_whilo    <= 1'b0;
      mem_hi       <= ZERO_WORD;
      mem_lo       <= ZERO_WORD;
      mem_aluop    <= EXE_NOP_OP;
      mem_mem_addr <= ZERO_WORD;
      mem_reg2     <= ZERO_WORD;
    end else if (flush || insert_bubble) begin
      mem_wd       <= NOP_REG_ADDR;
      mem_wreg     <= 1'b0;
      mem_wdata    <= ZERO_WORD;
      mem_whilo    <= 1'b0;
      mem_hi       <= ZERO_WORD;
      mem_lo       <= ZERO_WORD;
      mem_aluop    <= EXE_NOP_OP;
      mem_mem_addr <= ZERO_WORD;
      mem_reg2     <= ZERO_WORD;
    end else if (!hold_mem) begin
      mem_wd       <= ex_wd;
      mem_wreg     <= ex_wreg;
      mem_wdata    <= ex_wdata;
      mem_whilo    <= ex_whilo;
      mem_hi       <= ex_hi;
      mem_lo       <= ex_lo;
      mem_aluop    <= ex_aluop;
      mem_mem_addr <= ex_mem_addr;
      mem_reg2     <= ex_reg2;
    end
  end

  // Accumulate scratch: survives while EX is stalled, cleared once the instruction leaves EX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hilo_o <= 64'h0;
      cnt_o  <= 2'b00;
    end else if (flush) begin
      hilo_o <= 64'h0;
      cnt_o  <= 2'b00;
    end else if (ex_stalled) begin
      hilo_o <= hilo_i;
      cnt_o  <= cnt_i;
    end else begin
      hilo_o <= 64'h0;
      cnt_o  <= 2'b00;
    end
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb/tb_ex_mem_reg.sv - self-checking bench for ex_mem_reg
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        ex_whilo;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_reg2;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  int n_checks = 0;
  int n_fails  = 0;

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr),
    .ex_reg2(ex_reg2), .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr),
    .mem_reg2(mem_reg2), .hilo_o(hilo_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  // Instruction slot seen by MEM, and the accumulate scratch seen by EX
  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  aluop;
    logic [31:0] addr;
    logic [31:0] reg2;
  } slot_t;

  slot_t       exp_slot = '0;
  logic [63:0] exp_hilo = '0;
  logic [1:0]  exp_cnt  = '0;

  function automatic slot_t ex_slot();
    slot_t s;
    s = '{ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, ex_aluop, ex_mem_addr, ex_reg2};
    return s;
  endfunction

  // Reference: what MEM should be looking at after each edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_slot = '0;
      exp_hilo = '0;
      exp_cnt  = '0;
    end else begin
      if (flush) begin
        exp_slot = '0;
        exp_hilo = '0;
        exp_cnt  = '0;
      end else if (!stall[3]) begin
        exp_slot = ex_slot();
        exp_hilo = '0;
        exp_cnt  = '0;
      end else begin
        if (!stall[4]) exp_slot = '0;
        exp_hilo = hilo_i;
        exp_cnt  = cnt_i;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the reference, away from the rising edge
  always @(negedge clk) begin
    chk("mem_wd", 64'(mem_wd), 64'(exp_slot.wd));
    chk("mem_wreg", 64'(mem_wreg), 64'(exp_slot.wreg));
    chk("mem_wdata", 64'(mem_wdata), 64'(exp_slot.wdata));
    chk("mem_whilo", 64'(mem_whilo), 64'(exp_slot.whilo));
    chk("mem_hi", 64'(mem_hi), 64'(exp_slot.hi));
    chk("mem_lo", 64'(mem_lo), 64'(exp_slot.lo));
    chk("mem_aluop", 64'(mem_aluop), 64'(exp_slot.aluop));
    chk("mem_mem_addr", 64'(mem_mem_addr), 64'(exp_slot.addr));
    chk("mem_reg2", 64'(mem_reg2), 64'(exp_slot.reg2));
    chk("hilo_o", hilo_o, exp_hilo);
    chk("cnt_o", 64'(cnt_o), 64'(exp_cnt));
    chk("legal_stall", 64'(!stall[3] && stall[4]), 64'd0);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ex(input logic [4:0] wd, input logic [31:0] wdata, input logic [31:0] salt);
    ex_wd       = wd;
    ex_wreg     = salt[0];
    ex_wdata    = wdata;
    ex_whilo    = salt[1];
    ex_hi       = salt ^ 32'h1111_0000;
    ex_lo       = salt ^ 32'h0000_2222;
    ex_aluop    = salt[7:0] | 8'h20;
    ex_mem_addr = salt + 32'h100;
    ex_reg2     = ~salt;
    hilo_i      = {salt, ~wdata};
    cnt_i       = salt[3:2];
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    stall = 6'b0;
    set_ex(5'd9, 32'h5555_AAAA, 32'h0000_00F7);
    #1;
    chk("reset_wd", 64'(mem_wd), 64'd0);
    chk("reset_wdata", 64'(mem_wdata), 64'd0);
    chk("reset_cnt", 64'(cnt_o), 64'd0);
    cyc();
    cyc();
    chk("reset_held_wreg", 64'(mem_wreg), 64'd0);
    chk("reset_held_hilo", hilo_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Pass-through
    stall = 6'b0;
    set_ex(5'd3, 32'h1234_5678, 32'h0000_0001);
    ex_mem_addr = 32'h0000_0040;
    cyc();
    chk("pass_wd", 64'(mem_wd), 64'd3);
    chk("pass_wreg", 64'(mem_wreg), 64'd1);
    chk("pass_wdata", 64'(mem_wdata), 64'h1234_5678);
    chk("pass_addr", 64'(mem_mem_addr), 64'h40);
    chk("pass_hilo", hilo_o, 64'd0);
    chk("pass_cnt", 64'(cnt_o), 64'd0);

    // Bubble with accumulate state preserved, then release
    stall = 6'b001111;
    set_ex(5'd12, 32'h0BAD_F00D, 32'h0000_0001);
    hilo_i = 64'hAAAA_BBBB_CCCC_DDDD;
    cnt_i  = 2'b01;
    cyc();
    chk("bubble_wreg", 64'(mem_wreg), 64'd0);
    chk("bubble_wd", 64'(mem_wd), 64'd0);
    chk("bubble_hilo", hilo_o, 64'hAAAA_BBBB_CCCC_DDDD);
    chk("bubble_cnt", 64'(cnt_o), 64'd1);
    stall = 6'b0;
    set_ex(5'd7, 32'hCAFE_F00D, 32'h0000_0003);
    cyc();
    chk("release_wd", 64'(mem_wd), 64'd7);
    chk("release_wdata", 64'(mem_wdata), 64'hCAFE_F00D);
    chk("release_hilo", hilo_o, 64'd0);

    // Full hold
    set_ex(5'd4, 32'hDEAD_BEEF, 32'h0000_0005);
    cyc();
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      set_ex(5'(i + 20), 32'h0100_0000 * (i + 1), 32'h0000_0010 + i);
      cyc();
      chk("hold_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
      chk("hold_wd", 64'(mem_wd), 64'd4);
    end

    // Flush beats a stall in the middle of an accumulate
    stall = 6'b001111;
    set_ex(5'd5, 32'h7777_0000, 32'h0000_0004);
    cyc();
    chk("pre_flush_cnt", 64'(cnt_o), 64'd1);
    flush = 1'b1;
    cnt_i = 2'b01;
    cyc();
    chk("flush_cnt", 64'(cnt_o), 64'd0);
    chk("flush_hilo", hilo_o, 64'd0);
    chk("flush_wdata", 64'(mem_wdata), 64'd0);
    flush = 1'b0;

    // Async reset mid-accumulate
    stall = 6'b001111;
    hilo_i = 64'h0123_4567_89AB_CDEF;
    cnt_i  = 2'b01;
    cyc();
    chk("acc_cnt", 64'(cnt_o), 64'd1);
    chk("acc_hilo", hilo_o, 64'h0123_4567_89AB_CDEF);
    rst = 1'b1;
    #1;
    chk("async_cnt", 64'(cnt_o), 64'd0);
    chk("async_hilo", hilo_o, 64'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    stall = 6'b0;
    set_ex(5'd31, 32'hFFFF_0001, 32'h0000_0009);
    cyc();
    chk("post_rst_capture", 64'(mem_wdata), 64'hFFFF_0001);

    // Mixed directed sequence checked against the reference every cycle
    for (int i = 0; i < 24; i++) begin
      case (i % 6)
        0: stall = 6'b000000;
        1: stall = 6'b001111;
        2: stall = 6'b011111;
        3: stall = 6'b000000;
        4: stall = 6'b001111;
        default: stall = 6'b000000;
      endcase
      flush = (i == 10 || i == 19);
      set_ex(5'(i * 3), 32'h1000_0000 + 32'(i) * 32'h0101_0101, 32'(i * 37 + 11));
      cyc();
    end
    flush = 1'b0;
    stall = 6'b0;
    cyc();
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
